uart_txd_sniffer: RTL and testbench
===================================

Name: uart_txd_sniffer

Overview:
- Fabric-side UART receiver sitting directly downstream of the EMPU's uart0_txd pin.
- Decodes the MCU's serial console output (8N1) into bytes and buffers them in a small FIFO.
- Fabric logic (LED/debug/display consumers) pops bytes with a simple read strobe.
- Runs on the same clock as the MCU subsystem.

Parameters:
- CLK_HZ, 27000000, frequency of sys_clk in Hz.
- BAUD, 115200, line rate.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- Derived: CLKS_PER_BIT = CLK_HZ/BAUD (integer division; 234 at defaults); HALF_BIT = CLKS_PER_BIT/2 (117).

Ports:
- sys_clk  input  1  block clock.
- reset_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial input, tied to uart0_txd; idle high; asynchronous to sys_clk.
- rd_en  input  1  pop strobe; ignored when FIFO empty.
- clear  input  1  clears the sticky error flags.
- rd_data  output  8  FIFO head byte; first-word-fall-through.
- rd_valid  output  1  FIFO not empty.
- fifo_count  output  $clog2(DEPTH)+1  entries held.
- frame_err  output  1  sticky: stop bit sampled low.
- overflow  output  1  sticky: byte dropped because FIFO full.

Behaviour:
- Reset (async assert, sync release): state IDLE, synchronizer flops = 1, FIFO empty, rd_data=0, rd_valid=0, fifo_count=0, frame_err=0, overflow=0.
- Input path: rxd passes through a 2-flop synchronizer; all decode uses the synchronized signal rx_s.
- Bit-timer counter runs 0..CLKS_PER_BIT-1. State machine:
  - IDLE: a falling edge on rx_s (1 then 0) -> START, timer=0.
  - START: at timer==HALF_BIT-1, sample rx_s. If 0 -> DATA (timer=0, bit index=0). If 1 -> false start, back to IDLE; nothing is pushed and no flag is set.
  - DATA: sample at every timer==CLKS_PER_BIT-1 and shift LSB first. After the 8th sample -> STOP.
  - STOP: sample at timer==CLKS_PER_BIT-1. If 1: push byte, then IDLE. If 0: set frame_err, discard byte, -> BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A held-low line (break condition) therefore produces exactly one frame_err and no bytes.
- Latency: the push occurs on the stop-sample clock edge; rd_valid/rd_data reflect the byte on the following cycle.
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - fifo_count is 0..DEPTH.
  - rd_en while empty: no change.
  - Push while full with no rd_en: byte dropped, overflow set, contents unchanged.
  - Push while full with rd_en in the same cycle: pop and push both occur; count stays at DEPTH; no overflow.
  - Push while empty with rd_en in the same cycle: rd_en ignored (empty); push occurs.
- Flags: clear zeroes frame_err and overflow. If a set event and clear coincide, set wins (flag = 1).
- Reset mid-frame: the partial byte is lost. After release the block waits in IDLE for the next falling edge; a line already low at release does not start a frame until it returns high and falls again.

Optional Feature:
- Macro: UART_SNIFF_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizer (rx_f = majority of the last 3 rx_s samples), with reset value 111. All edge detection and sampling use rx_f. This suppresses 1-cycle glitches and adds 1 cycle of fixed latency.
- Undefined: decode uses rx_s directly; no filter registers are present.

Test Plan:
- Send 0xA5 as 8N1 at 115200 (234 clocks/bit) -> rd_valid=1 and rd_data=0xA5 within 1 cycle after the stop sample; fifo_count=1; rd_en pulse -> fifo_count=0, rd_valid=0.
- Pulse rxd low for 50 clocks from idle -> false start; no push; frame_err=0; the next valid frame 0x3C decodes correctly.
- Frame 0x55 with stop bit driven low, then line held low for 3000 clocks -> frame_err=1, fifo_count=0, no further activity; release high and send 0x81 -> 0x81 pushed; clear -> frame_err=0.
- DEPTH=16: send bytes 0x00..0x10 (17 bytes) with no reads -> fifo_count=16, overflow=1; pops return 0x00..0x0F in order.
- FIFO full with rd_en asserted on the exact push cycle of 0x20 -> count remains 16, overflow stays 0, 0x20 appears last.
- With UART_SNIFF_FILTER_EN: inject a 1-cycle high glitch at the centre of a 0 data bit of 0x00 -> 0x00 received. Without the macro, the same stimulus changes the received value, confirming the filter is compiled out.

Source files
------------

// File: rtl/uart_txd_sniffer.sv
// uart_txd_sniffer: 8N1 receiver on the MCU console pin feeding a small
// first-word-fall-through FIFO with sticky frame-error/overflow flags.
// Optional build macro UART_SNIFF_FILTER_EN inserts a 3-sample majority
// glitch filter after the synchronizer.
module uart_txd_sniffer #(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     rxd,
    input  logic                     rd_en,
    input  logic                     clear,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     frame_err,
    output logic                     overflow
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rx_meta, rx_s, rx_d, rx_prev;
    logic [4:0]    settle;
    logic          line_ok;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_hit, push_req, ferr_set;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, do_push, ovf_set;

    // two-flop synchronizer for the asynchronous serial line (idle high)
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_SNIFF_FILTER_EN
    logic [1:0] rx_hist;

    // two previous rx_s samples; together with rx_s they form the 3-sample window
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) rx_hist <= 2'b11;
        else          rx_hist <= {rx_hist[0], rx_s};
    end

    assign rx_d = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
    assign rx_d = rx_s;
`endif

    // rx_prev feeds the edge detector; settle blocks edge detection until the
    // reset-preset 1s have flushed out, so a line held low across reset is not
    // mistaken for a start bit
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_prev <= 1'b1;
            settle  <= '0;
        end else begin
            rx_prev <= rx_d;
            settle  <= {settle[3:0], 1'b1};
        end
    end

    assign line_ok  = settle[4];
    assign stop_hit = (state == S_STOP) && (timer == TW'(CLKS_PER_BIT - 1));
    assign push_req = stop_hit && rx_d;
    assign ferr_set = stop_hit && !rx_d;

    // frame decoder: start validated at half bit, data/stop at full-bit steps
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (line_ok && rx_prev && !rx_d) state <= S_START;
                end
                S_START: begin
                    if (timer == TW'(HALF_BIT - 1)) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_d ? S_IDLE : S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer == TW'(CLKS_PER_BIT - 1)) begin
                        timer   <= '0;
                        shreg   <= {rx_d, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_hit) begin
                        timer <= '0;
                        state <= rx_d ? S_IDLE : S_BREAK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_BREAK: begin
                    timer <= '0;
                    if (rx_d) state <= S_IDLE;
                end
                default: begin
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign full    = (count == (AW + 1)'(DEPTH));
    assign pop     = rd_en && (count != '0);
    assign do_push = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    // FIFO storage; cleared on reset so the head reads 0 before any push
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers and occupancy; simultaneous push+pop leaves count unchanged
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // sticky error flags; a set event outranks a coincident clear
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (ferr_set)   frame_err <= 1'b1;
            else if (clear) frame_err <= 1'b0;
            if (ovf_set)    overflow  <= 1'b1;
            else if (clear) overflow  <= 1'b0;
        end
    end

    assign rd_data    = mem[rd_ptr];
    assign rd_valid   = (count != '0);
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_txd_sniffer.sv
// Scoreboard bench for uart_txd_sniffer at default parameters (234 clk/bit).
module tb_uart_txd_sniffer;

    localparam int CPB  = 27000000 / 115200;
    localparam int HALF = CPB / 2;
`ifdef UART_SNIFF_FILTER_EN
    localparam int FLT  = 1;
`else
    localparam int FLT  = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       reset_n, rxd, rd_en, clear;
    logic [7:0] rd_data;
    logic       rd_valid, frame_err, overflow;
    logic [4:0] fifo_count;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    uart_txd_sniffer #(.CLK_HZ(27000000), .BAUD(115200), .DEPTH(16)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .rxd(rxd), .rd_en(rd_en), .clear(clear),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // compare head against the scoreboard, then pop it
    task automatic pop_check(input string tag);
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h1ff;
        chk({tag, "_v"}, rd_valid, 1);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // one 8N1 frame starting right after a clock edge; optional 1-cycle high
    // glitch centred on data bit glitch_bit, optional pop on the push edge
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit,
                              input bit pop_at_push, input bit expect_push, input logic [7:0] exp_b);
        if (expect_push) exp_q.push_back(exp_b);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == glitch_bit) begin
                repeat (HALF) tick();
                rxd = 1'b1;
                tick();
                rxd = b[i];
                repeat (CPB - HALF - 1) tick();
            end else begin
                repeat (CPB) tick();
            end
        end
        rxd = stop_v;
        if (pop_at_push) begin
            repeat (2 + HALF + FLT) tick();
            pop_check("pop_on_push");
            repeat (CPB - 3 - HALF - FLT) tick();
        end else begin
            repeat (CPB) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clear   = 1'b0;
        repeat (5) tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        repeat (10) tick();

        // basic frame
        send_frame(8'hA5, 1'b1, -1, 1'b0, 1'b1, 8'hA5);
        chk("a5_count", fifo_count, 1);
        pop_check("a5_data");
        chk("a5_empty_count", fifo_count, 0);
        chk("a5_empty_valid", rd_valid, 0);

        // short low pulse is a false start
        rxd = 1'b0;
        repeat (50) tick();
        rxd = 1'b1;
        repeat (300) tick();
        chk("false_count", fifo_count, 0);
        chk("false_ferr", frame_err, 0);
        send_frame(8'h3C, 1'b1, -1, 1'b0, 1'b1, 8'h3C);
        pop_check("3c_data");

        // bad stop then break: one frame error, nothing buffered
        send_frame(8'h55, 1'b0, -1, 1'b0, 1'b0, 8'h00);
        repeat (3000) tick();
        chk("brk_ferr", frame_err, 1);
        chk("brk_count", fifo_count, 0);
        rxd = 1'b1;
        repeat (20) tick();
        send_frame(8'h81, 1'b1, -1, 1'b0, 1'b1, 8'h81);
        chk("81_count", fifo_count, 1);
        pop_check("81_data");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ferr", frame_err, 0);

        // fill past full: 0x10 dropped
        for (int b = 0; b < 17; b++)
            send_frame(8'(b), 1'b1, -1, 1'b0, (b < 16), 8'(b));
        chk("full_count", fifo_count, 16);
        chk("full_ovf", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", overflow, 0);

        // push into a full FIFO while popping on the same edge
        send_frame(8'h20, 1'b1, -1, 1'b1, 1'b1, 8'h20);
        chk("pp_count", fifo_count, 16);
        chk("pp_ovf", overflow, 0);
        for (int k = 0; k < 16; k++) pop_check("drain");
        chk("drain_count", fifo_count, 0);

        // glitch on bit 3 of 0x00: filtered out only when the filter is built in
`ifdef UART_SNIFF_FILTER_EN
        send_frame(8'h00, 1'b1, 3, 1'b0, 1'b1, 8'h00);
`else
        send_frame(8'h00, 1'b1, 3, 1'b0, 1'b1, 8'h08);
`endif
        pop_check("glitch_data");

        // reset mid-frame with the line still low after release
        rxd = 1'b0;
        repeat (1000) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3000) tick();
        chk("rmf_count", fifo_count, 0);
        chk("rmf_ferr", frame_err, 0);
        rxd = 1'b1;
        repeat (20) tick();
        send_frame(8'h5A, 1'b1, -1, 1'b0, 1'b1, 8'h5A);
        pop_check("rmf_5a");
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
